// File: rtl/stopwatch_pkg.sv
// Shared channel state encoding and lockout sizing for the stopwatch controller.
// Used by stopwatch_ctrl and stopwatch_ctrl_chan; lap support is gated by STOPWATCH_CTRL_LAP_EN.
package stopwatch_pkg;

  localparam logic [1:0] ST_STOPPED = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_HOLD    = 2'b10;

  localparam int LOCKOUT_DEF = 16;

  // Counter must hold LOCKOUT itself; a zero lockout still needs a 1-bit register.
  function automatic int lock_width(input int lockout);
    return (lockout < 1) ? 1 : $clog2(lockout + 1);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_chan.sv
// One stopwatch channel: edge detect + lockout blanking per input, run/hold FSM, clear strobe.
// Outputs are registered (one cycle after the sampled edge); no backpressure. Lap/HOLD needs STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl_chan
  import stopwatch_pkg::*;
#(
  parameter int LOCKOUT = LOCKOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic lap_i,
  input  logic clear_i,
  input  logic stop_all_i,
  output logic run_o,
  output logic hold_o,
  output logic clr_o
);

  localparam int CW = lock_width(LOCKOUT);
  localparam logic [CW-1:0] LOAD = CW'(LOCKOUT);
  localparam int IDX_START = 0;
  localparam int IDX_CLR   = 1;
`ifdef STOPWATCH_CTRL_LAP_EN
  localparam int IDX_LAP   = 2;
  localparam int NIN       = 3;
`else
  localparam int NIN       = 2;
`endif

  logic [NIN-1:0] in_vec;
  logic [NIN-1:0] prev_q;
  logic [NIN-1:0] acc;
  logic [CW-1:0]  lock_q [NIN];
  logic [CW-1:0]  lock_d [NIN];
  logic [1:0]     state_q, state_d;
  logic           clr_q, clr_d;

`ifdef STOPWATCH_CTRL_LAP_EN
  assign in_vec = {lap_i, clear_i, start_i};
`else
  logic unused_lap;
  assign unused_lap = lap_i;
  assign in_vec = {clear_i, start_i};
`endif

  // Rejected edges are dropped outright; only an accepted edge reloads the blanking counter.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NIN; i++) begin
      acc[i] = in_vec[i] && !prev_q[i] && (lock_q[i] == '0);
      if (acc[i]) begin
        lock_d[i] = LOAD;
      end else if (lock_q[i] != '0) begin
        lock_d[i] = lock_q[i] - CW'(1);
      end else begin
        lock_d[i] = lock_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = acc[IDX_CLR] && (state_q == ST_STOPPED);
    if (stop_all_i) begin
      state_d = ST_STOPPED;
    end else if (acc[IDX_START]) begin
      state_d = (state_q == ST_STOPPED) ? ST_RUNNING : ST_STOPPED;
`ifdef STOPWATCH_CTRL_LAP_EN
    end else if (acc[IDX_LAP]) begin
      if (state_q == ST_RUNNING) begin
        state_d = ST_HOLD;
      end else if (state_q == ST_HOLD) begin
        state_d = ST_RUNNING;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      state_q <= ST_STOPPED;
      clr_q   <= 1'b0;
      for (int i = 0; i < NIN; i++) begin
        lock_q[i] <= '0;
      end
    end else begin
      prev_q  <= in_vec;
      state_q <= state_d;
      clr_q   <= clr_d;
      for (int i = 0; i < NIN; i++) begin
        lock_q[i] <= lock_d[i];
      end
    end
  end

  assign run_o = (state_q != ST_STOPPED);
  assign clr_o = clr_q;
`ifdef STOPWATCH_CTRL_LAP_EN
  assign hold_o = (state_q == ST_HOLD);
`else
  assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/stopwatch_ctrl.sv
// Multi-channel stopwatch run/stop/lap controller; one stopwatch_ctrl_chan per channel plus global stop.
// Registered outputs one cycle after the edge, any_run_o adds no latency; no backpressure. Lap via STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int LOCKOUT  = LOCKOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] start_i,
  input  logic [CHANNELS-1:0] lap_i,
  input  logic [CHANNELS-1:0] clear_i,
  input  logic                stop_all_i,
  output logic [CHANNELS-1:0] run_o,
  output logic [CHANNELS-1:0] hold_o,
  output logic [CHANNELS-1:0] clr_o,
  output logic                any_run_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    stopwatch_ctrl_chan #(
      .LOCKOUT(LOCKOUT)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start_i[c]),
      .lap_i     (lap_i[c]),
      .clear_i   (clear_i[c]),
      .stop_all_i(stop_all_i),
      .run_o     (run_o[c]),
      .hold_o    (hold_o[c]),
      .clr_o     (clr_o[c])
    );
  end

  assign any_run_o = |run_o;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 4; number of independent run/stop channels, 1..16.
REQ-002 SHALL have parameter LOCKOUT, default 16; cycles after an accepted edge during which further edges on the same input are ignored; 0 disables blanking.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as below.
REQ-004 SHALL have port clk, input, 1; sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1; asynchronous assert, active-low reset.
REQ-006 SHALL have port start_i, input, CHANNELS; per-channel start/stop pulse, already synchronous to clk.
REQ-007 SHALL have port lap_i, input, CHANNELS; per-channel lap (display-freeze) pulse.
REQ-008 SHALL have port clear_i, input, CHANNELS; per-channel count-clear request.
REQ-009 SHALL have port stop_all_i, input, 1; global stop, level-sensitive.
REQ-010 SHALL have port run_o, output, CHANNELS; channel counter enable.
REQ-011 SHALL have port hold_o, output, CHANNELS; channel display freeze.
REQ-012 SHALL have port clr_o, output, CHANNELS; one-cycle counter clear strobe.
REQ-013 SHALL have port any_run_o, output, 1; OR of run_o.

Function
REQ-014 SHALL detect rising edges per input bit: edge = input high and registered previous value low; a held-high input produces exactly one edge.
REQ-015 SHALL accept an edge only when that input's lockout counter is 0; acceptance loads the counter with LOCKOUT, which decrements to 0 each cycle; rejected edges are discarded, not queued.
REQ-016 SHALL implement per-channel states STOPPED (run 0, hold 0), RUNNING (run 1, hold 0), HOLD (run 1, hold 1).
REQ-017 SHALL transition: STOPPED+start -> RUNNING; RUNNING+start -> STOPPED; RUNNING+lap -> HOLD; HOLD+lap -> RUNNING; HOLD+start -> STOPPED; STOPPED+lap -> no change.
REQ-018 SHALL give start priority over lap when both edges are accepted in the same cycle.
REQ-019 SHALL, while stop_all_i is high, force every channel to STOPPED and discard all start/lap edges, while still updating edge history and lockout counters.
REQ-020 SHALL pulse clr_o[c] high for exactly one cycle on an accepted clear_i[c] rising edge when channel c is STOPPED; clear edges in RUNNING or HOLD are ignored.
REQ-021 SHALL register run_o, hold_o and clr_o: each reflects the edge sampled in cycle t during cycle t+1.
REQ-022 SHALL derive any_run_o combinationally from registered run_o, with no added latency.
REQ-023 SHALL keep channels fully independent; activity on one channel never alters another except via stop_all_i.

Reset
REQ-024 SHALL, on rst_n low, immediately set all channels to STOPPED, run_o, hold_o, clr_o, any_run_o to 0, edge history registers to 0, and lockout counters to 0.
REQ-025 SHALL, when rst_n deasserts while an input is held high, treat that level as a new rising edge on the first clock.
REQ-026 SHALL, on reset mid-operation, abandon any HOLD or lockout state with no residual clr_o pulse.

Configuration
REQ-027 SHALL, with macro STOPWATCH_CTRL_LAP_EN defined, implement the HOLD state and lap_i as specified.
REQ-028 SHALL, without STOPWATCH_CTRL_LAP_EN, ignore lap_i, omit HOLD state and its edge/lockout logic, and tie hold_o to 0.

Structure
REQ-029 SHALL place channel state encoding (STOPPED=2'b00, RUNNING=2'b01, HOLD=2'b10) and the default LOCKOUT value in shared package stopwatch_pkg.
REQ-030 SHALL implement one channel in sub-module stopwatch_ctrl_chan, instantiated CHANNELS times by generate loop; lockout counter width is $clog2(LOCKOUT+1), minimum 1.

Verification
REQ-031 SHALL verify: start_i[0] 1-cycle pulse at cycle 10 -> run_o[0]=1 from cycle 11; second pulse at cycle 40 -> run_o[0]=0 from cycle 41.
REQ-032 SHALL verify: LOCKOUT=16, start_i[1] pulses at cycles 10 and 20 -> only first accepted, run_o[1]=1; a pulse at cycle 30 -> run_o[1]=0.
REQ-033 SHALL verify (LAP_EN): RUNNING, start_i[2] and lap_i[2] rising same cycle -> STOPPED, hold_o[2]=0.
REQ-034 SHALL verify: channels 0 and 3 RUNNING, stop_all_i high 5 cycles with start_i[0] pulse inside -> run_o=4'b0000 and any_run_o=0 the cycle after stop_all_i rises, still 0 after it drops.
REQ-035 SHALL verify: clear_i[1] edge while STOPPED -> clr_o[1] high exactly 1 cycle; clear_i[1] edge while RUNNING -> clr_o[1] stays 0.
REQ-036 SHALL verify: rst_n low asynchronously mid-HOLD -> all outputs 0 before next clk edge; start_i[0] held high across deassert -> run_o[0]=1 one cycle after first clock.
